// File: rtl/capture_if.sv
// Host/AFE-side bundle for capture_ctrl: trigger pins, capture configuration,
// readout request and the RAM write/readout port.
interface capture_if #(
    parameter int ADDR_W = 9,
    parameter int DEC_W  = 4
);
    logic              trig1;
    logic              trig2;
    logic              arm;
    logic [1:0]        trig_src;
    logic              trig_edge;
    logic [ADDR_W-1:0] trig_pos;
    logic [DEC_W-1:0]  dec_pwr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              adc_clk;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] trig_addr;
    logic              busy;
    logic              capture_done;

    modport master (
        output trig1, trig2, arm, trig_src, trig_edge, trig_pos, dec_pwr, rd_addr, rd_en,
        input  adc_clk, en, we, addr, trig_addr, busy, capture_done
    );

    modport slave (
        input  trig1, trig2, arm, trig_src, trig_edge, trig_pos, dec_pwr, rd_addr, rd_en,
        output adc_clk, en, we, addr, trig_addr, busy, capture_done
    );
endinterface

// File: rtl/capture_ctrl.sv
// Sample-capture controller: decimated circular-buffer writes, edge trigger,
// post-trigger count, then frozen buffer readout. CAP_AUTOTRIG_EN adds an ARMED timeout.
//
// state   | meaning
// IDLE    | no capture, RAM port quiet
// PREFILL | filling pre-trigger history, triggers ignored
// ARMED   | writing, waiting for trigger edge / force / timeout
// POST    | writing the post-trigger samples
// DONE    | buffer frozen, RAM port driven by readout
module capture_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DEC_W  = 4
) (
    input logic      clk,
    input logic      rst,
    capture_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = 1 << DEC_W;

    typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, DONE} state_t;

    state_t            state;
    logic              adc_clk_q, en_q, we_q, busy_q, done_q;
    logic [ADDR_W-1:0] addr_q, trig_addr_q, wptr, post_cnt, pos_q;
    logic [ADDR_W:0]   pre_cnt, pre_thr;
    logic [CNT_W-1:0]  dec_cnt, dec_mask;
    logic [DEC_W-1:0]  dec_q;
    logic [1:0]        src_q;
    logic              edge_q;
    logic [2:0]        sync1, sync2;
    logic              smp, wq, sel_cur, sel_prev, trig_hit, timeout_hit, do_write;

    assign smp      = adc_clk_q;
    assign dec_mask = (CNT_W'(1) << dec_q) - CNT_W'(1);
    assign wq       = smp && ((dec_cnt & dec_mask) == '0);
    assign pre_thr  = (ADDR_W+1)'(DEPTH) - {1'b0, pos_q};

    // bit 1 of each chain is the synchronized level, bit 2 its previous value
    assign sel_cur  = src_q[0] ? sync2[1] : sync1[1];
    assign sel_prev = src_q[0] ? sync2[2] : sync1[2];
    assign trig_hit = src_q[1] | (edge_q ? (sel_cur & ~sel_prev) : (~sel_cur & sel_prev));

    assign do_write = wq && !bus.arm &&
                      ((state == PREFILL) || (state == ARMED) ||
                       ((state == POST) && (post_cnt != '0)));

`ifdef CAP_AUTOTRIG_EN
    logic [15:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || bus.arm) to_cnt <= '0;
        else if ((state == ARMED) && wq) to_cnt <= to_cnt + 16'd1;
    end

    // fires on the 65535th ARMED write without a trigger
    assign timeout_hit = (state == ARMED) && wq && (to_cnt == 16'hFFFE);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            adc_clk_q   <= 1'b0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            trig_addr_q <= '0;
            wptr        <= '0;
            post_cnt    <= '0;
            pos_q       <= '0;
            pre_cnt     <= '0;
            dec_cnt     <= '0;
            dec_q       <= '0;
            src_q       <= '0;
            edge_q      <= 1'b0;
            sync1       <= '0;
            sync2       <= '0;
        end else begin
            adc_clk_q <= ~adc_clk_q;
            sync1     <= {sync1[1:0], bus.trig1};
            sync2     <= {sync2[1:0], bus.trig2};
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            if (smp) dec_cnt <= dec_cnt + CNT_W'(1);

            if (do_write) begin
                en_q   <= 1'b1;
                we_q   <= 1'b1;
                addr_q <= wptr;
                wptr   <= wptr + ADDR_W'(1);
            end

            // arm restarts from any state and masks a same-cycle trigger edge
            if (bus.arm) begin
                state   <= PREFILL;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                wptr    <= '0;
                pre_cnt <= '0;
                dec_cnt <= '0;
                pos_q   <= bus.trig_pos;
                src_q   <= bus.trig_src;
                edge_q  <= bus.trig_edge;
                dec_q   <= bus.dec_pwr;
            end else begin
                case (state)
                    IDLE: ;
                    PREFILL: begin
                        if (wq) begin
                            pre_cnt <= pre_cnt + (ADDR_W+1)'(1);
                            if ((pre_cnt + (ADDR_W+1)'(1)) >= pre_thr) state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (trig_hit || timeout_hit) begin
                            state    <= POST;
                            post_cnt <= pos_q;
                        end
                    end
                    POST: begin
                        if (post_cnt == '0) begin
                            state       <= DONE;
                            trig_addr_q <= wptr;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else if (wq) begin
                            post_cnt <= post_cnt - ADDR_W'(1);
                        end
                    end
                    DONE: begin
                        en_q   <= bus.rd_en;
                        addr_q <= bus.rd_addr;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.adc_clk      = adc_clk_q;
    assign bus.en           = en_q;
    assign bus.we           = we_q;
    assign bus.addr         = addr_q;
    assign bus.trig_addr    = trig_addr_q;
    assign bus.busy         = busy_q;
    assign bus.capture_done = done_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: driver predicts write count, done cycle and
// trig_addr from the capture rules; a monitor checks every RAM write and each completion.
module tb_capture_ctrl;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    capture_if #(.ADDR_W(AW), .DEC_W(4)) bus ();
    capture_ctrl #(.ADDR_W(AW), .DEC_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int r_edge   = 0;

    typedef struct { int n; int d; } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Writes fall on every 2^(d+1)-th edge starting at the first sample edge after arm.
    // Prefill takes DEPTH-p writes; the trigger is acted on 2 edges after the pin is
    // sampled; p post writes follow and DONE lands one edge after the last of them.
    function automatic void predict(input int a, input int d, input int p, input bit forced,
                                    input int k, output int n, output int dn, output int wa);
        int per, f, thr, t, pre;
        per = 2 << d;
        f   = a + 1;
        if (((f - r_edge) % 2) != 0) f++;
        thr = DEPTH - p;
        wa  = f + (thr - 1) * per;
        t   = forced ? wa + 1 : k + 2;
        pre = (t - f) / per + 1;
        n   = pre + p;
        dn  = (p == 0) ? t + 1 : f + (n - 1) * per + 1;
    endfunction

    int wcount = 0;
    bit done_prev = 1'b0;

    initial begin : monitor
        bit   a, r;
        exp_t e;
        forever begin
            @(posedge clk);
            a = bus.arm;
            r = rst;
            #1;
            if (r) begin
                wcount = 0;
            end else begin
                if (a) wcount = 0;
                if (bus.en && bus.we) begin
                    check("wr_addr", bus.addr, wcount % DEPTH);
                    wcount++;
                end
                if (bus.capture_done && !done_prev) begin
                    check("done_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("write_count", wcount, e.n);
                        check("trig_addr", bus.trig_addr, e.n % DEPTH);
                        check("done_cycle", cyc, e.d);
                    end
                end
            end
            done_prev = bus.capture_done;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive_pin(input int src, input logic val);
        if (src == 1) bus.trig2 = val;
        else          bus.trig1 = val;
    endtask

    task automatic do_arm(input int d, input int p, input int src, input int edg, output int a);
        @(negedge clk);
        bus.dec_pwr   = 4'(d);
        bus.trig_pos  = AW'(p);
        bus.trig_src  = 2'(src);
        bus.trig_edge = 1'(edg);
        bus.arm       = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        a       = cyc;
        // configuration is latched at arm; scramble it for the rest of the capture
        bus.dec_pwr   = 4'($urandom);
        bus.trig_pos  = AW'($urandom);
        bus.trig_src  = 2'($urandom);
        bus.trig_edge = 1'($urandom);
    endtask

    task automatic run_capture(input int d, input int p, input int src, input int edg,
                               input int delay, input bit restart, input bit glitch);
        int   a, n, dn, wa, k;
        logic idle;
        exp_t e;
        idle     = (edg != 0) ? 1'b0 : 1'b1;
        bus.trig1 = idle;
        bus.trig2 = idle;
        tick(6);
        if (restart) begin
            do_arm(d, p, src, edg, a);
            tick($urandom_range(5, 100));
        end
        do_arm(d, p, src, edg, a);
        predict(a, d, p, 1'b1, 0, n, dn, wa);
        if (src >= 2) begin
            e.n = n;
            e.d = dn;
            sb.push_back(e);
        end else begin
            if (glitch) begin
                tick(20);
                drive_pin(src, ~idle);
                tick(10);
                drive_pin(src, idle);
            end
            wait_until(wa + delay);
            check("busy_armed", bus.busy, 1);
            check("done_armed", bus.capture_done, 0);
            k = cyc + 1;
            predict(a, d, p, 1'b0, k, n, dn, wa);
            e.n = n;
            e.d = dn;
            sb.push_back(e);
            drive_pin(src, ~idle);
            drive_pin((src == 1) ? 0 : 1, ~idle);
        end
        wait_until(dn + 2);
        check("done_flag", bus.capture_done, 1);
        check("busy_done", bus.busy, 0);
    endtask

    task automatic readout(input int ra);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(ra);
        @(negedge clk);
        check("rd_addr", bus.addr, ra);
        check("rd_we", bus.we, 0);
        check("rd_en", bus.en, 1);
        bus.rd_en = 1'b0;
        @(negedge clk);
        check("rd_en_off", bus.en, 0);
    endtask

    initial begin : driver
        int a, n, dn, wa;
        bus.trig1     = 1'b0;
        bus.trig2     = 1'b0;
        bus.arm       = 1'b0;
        bus.trig_src  = 2'd0;
        bus.trig_edge = 1'b1;
        bus.trig_pos  = '0;
        bus.dec_pwr   = '0;
        bus.rd_addr   = '0;
        bus.rd_en     = 1'b0;

        tick(3);
        check("rst_en", bus.en, 0);
        check("rst_we", bus.we, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_trig_addr", bus.trig_addr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.capture_done, 0);
        check("rst_adc_clk", bus.adc_clk, 0);
        rst    = 1'b0;
        r_edge = cyc;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("adc_clk", bus.adc_clk, (cyc - r_edge) & 1);
        end
        check("idle_busy", bus.busy, 0);

        run_capture(0, 256, 0, 1, 488, 1'b0, 1'b0);
        readout(5);
        run_capture(3, 64, 0, 1, 37, 1'b0, 1'b0);
        run_capture(0, 100, 1, 0, 23, 1'b0, 1'b1);
        run_capture(0, 0, 2, 1, 0, 1'b0, 1'b0);
        readout(5);
        run_capture(1, 300, 1, 1, 11, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_capture($urandom_range(0, 2), $urandom_range(0, DEPTH - 1), $urandom_range(0, 3),
                        $urandom_range(0, 1), $urandom_range(0, 200), 1'($urandom_range(0, 1)), 1'b0);
            readout($urandom_range(0, DEPTH - 1));
        end

        // no trigger: capture must stay busy (timeout, when built in, is far away)
        bus.trig1 = 1'b0;
        bus.trig2 = 1'b0;
        tick(6);
        do_arm(0, 10, 0, 1, a);
        predict(a, 0, 10, 1'b1, 0, n, dn, wa);
        wait_until(wa);
        for (int i = 0; i < 4; i++) begin
            bus.trig2 = ~bus.trig2;
            tick(10);
        end
        wait_until(wa + 3000);
        check("notrig_busy", bus.busy, 1);
        check("notrig_done", bus.capture_done, 0);

        // re-arm while ARMED with force, then reset in the middle of POST
        do_arm(0, 400, 2, 1, a);
        predict(a, 0, 400, 1'b1, 0, n, dn, wa);
        wait_until(wa + 10);
        check("post_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_en", bus.en, 0);
        check("midrst_we", bus.we, 0);
        check("midrst_addr", bus.addr, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.capture_done, 0);
        check("midrst_trig_addr", bus.trig_addr, 0);
        rst    = 1'b0;
        r_edge = cyc;
        tick(2);
        check("postrst_busy", bus.busy, 0);

        run_capture(0, 50, 3, 0, 0, 1'b0, 1'b0);

        tick(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
